// File: rtl/return_address_stack.sv
// return_address_stack: circular return-address predictor stack with pipeline rollback and ra tracking.
//   clk                   : sole clock, rising edge
//   rst_n                 : synchronous active-low reset
//   RAS_push/_push_data   : push a return address
//   RAS_pop               : pop the top entry
//   RAS_rollback_pop_id   : undo one push from a flushed ID instruction
//   RAS_rollback_push_id  : undo one pop from a flushed ID instruction
//   RAS_rollback_push_ex  : undo one pop from a flushed EX instruction
//   WR_ra_track_en/_data  : load the tracked ra-holding register
//   RAS_top               : mem[ptr-1], combinational array read
//   RAS_empty             : count == 0
//   RAS_ra_track          : register currently holding ra
module return_address_stack #(
   parameter int DEPTH = 8,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          RAS_push,
   input  logic [AW-1:0] RAS_push_data,
   input  logic          RAS_pop,
   input  logic          RAS_rollback_pop_id,
   input  logic          RAS_rollback_push_id,
   input  logic          RAS_rollback_push_ex,
   input  logic          WR_ra_track_en,
   input  logic [4:0]    WR_ra_track_data,
   output logic [AW-1:0] RAS_top,
   output logic          RAS_empty,
   output logic [4:0]    RAS_ra_track
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
   logic [AW-1:0] mem_q [DEPTH];
   logic [PW-1:0] ptr_q, ptr_d, top_idx, wr_idx;
   logic [PW:0] count_q, count_d, count_clamp;
   logic [4:0] ra_track_q, ra_track_d;
   logic rollback, we, full, empty;
   logic signed [2:0] delta;
   logic signed [PW+2:0] count_rb;
   assign rollback = RAS_rollback_pop_id | RAS_rollback_push_id | RAS_rollback_push_ex;
   assign top_idx  = ptr_q - 1'b1;
   assign full     = count_q == FULL;
   assign empty    = count_q == '0;
   // delta spans -1..+2; 3-bit modular arithmetic gives the two's-complement value
   assign delta    = $signed(3'(RAS_rollback_push_id) + 3'(RAS_rollback_push_ex) - 3'(RAS_rollback_pop_id));
   assign count_rb = $signed({2'b00, count_q}) + delta;
   assign count_clamp = count_rb[PW+2] ? '0 : count_rb > $signed({2'b00, FULL}) ? FULL : count_rb[PW:0];
   always_comb begin
      ptr_d = rollback              ? ptr_q + PW'(delta) :
              RAS_push && !RAS_pop  ? ptr_q + 1'b1 :
              !RAS_push && RAS_pop  ? top_idx : ptr_q;
      count_d = rollback             ? count_clamp :
                RAS_push && RAS_pop  ? (empty ? (PW+1)'(1) : count_q) :
                RAS_push             ? (full ? count_q : count_q + 1'b1) :
                RAS_pop              ? (empty ? count_q : count_q - 1'b1) : count_q;
      we         = !rollback && RAS_push;
      // push+pop replaces the top in place; a plain push fills the free slot
      wr_idx     = RAS_pop ? top_idx : ptr_q;
      ra_track_d = WR_ra_track_en ? WR_ra_track_data : we ? 5'd1 : ra_track_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         count_q    <= '0;
         ra_track_q <= 5'd1;
      end else begin
         ptr_q      <= ptr_d;
         count_q    <= count_d;
         ra_track_q <= ra_track_d;
      end
   end
   // array is not reset; popped entries stay put so rollback can re-expose them
   always_ff @(posedge clk) begin
      if (rst_n && we) mem_q[wr_idx] <= RAS_push_data;
   end
   assign RAS_top      = mem_q[top_idx];
   assign RAS_empty    = empty;
   assign RAS_ra_track = ra_track_q;
endmodule

// File: tb/tb_return_address_stack.sv
// tb_return_address_stack: directed self-checking bench for return_address_stack.
module tb_return_address_stack;
   logic        clk, rst_n;
   logic        RAS_push, RAS_pop;
   logic [31:0] RAS_push_data;
   logic        RAS_rollback_pop_id, RAS_rollback_push_id, RAS_rollback_push_ex;
   logic        WR_ra_track_en;
   logic [4:0]  WR_ra_track_data;
   logic [31:0] RAS_top;
   logic        RAS_empty;
   logic [4:0]  RAS_ra_track;
   int vectors = 0;
   int miscompares = 0;

   return_address_stack #(.DEPTH(8), .AW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .RAS_push(RAS_push), .RAS_push_data(RAS_push_data), .RAS_pop(RAS_pop),
      .RAS_rollback_pop_id(RAS_rollback_pop_id),
      .RAS_rollback_push_id(RAS_rollback_push_id),
      .RAS_rollback_push_ex(RAS_rollback_push_ex),
      .WR_ra_track_en(WR_ra_track_en), .WR_ra_track_data(WR_ra_track_data),
      .RAS_top(RAS_top), .RAS_empty(RAS_empty), .RAS_ra_track(RAS_ra_track)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic cyc(input logic psh, input logic [31:0] d, input logic pp,
                      input logic rpo, input logic rpi, input logic rpe,
                      input logic te, input logic [4:0] td, input logic rn);
      RAS_push = psh; RAS_push_data = d; RAS_pop = pp;
      RAS_rollback_pop_id = rpo; RAS_rollback_push_id = rpi; RAS_rollback_push_ex = rpe;
      WR_ra_track_en = te; WR_ra_track_data = td; rst_n = rn;
      @(posedge clk);
      #1;
      RAS_push = 0; RAS_pop = 0; RAS_rollback_pop_id = 0; RAS_rollback_push_id = 0;
      RAS_rollback_push_ex = 0; WR_ra_track_en = 0; rst_n = 1;
   endtask

   task automatic do_reset();   cyc(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic do_push(input logic [31:0] d); cyc(1, d, 0, 0, 0, 0, 0, 0, 1); endtask
   task automatic do_pop();     cyc(0, 0, 1, 0, 0, 0, 0, 0, 1); endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (RAS_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %0b want 1", RAS_empty); end
      vectors++; if (RAS_ra_track !== 5'd1) begin miscompares++; $display("FAIL reset_ra_track got %0d want 1", RAS_ra_track); end
      vectors++; if (dut.count_q !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", dut.count_q); end
   endtask

   task automatic test_push_pop();
      do_reset();
      do_push(32'h100); do_push(32'h200); do_push(32'h300);
      vectors++; if (RAS_top !== 32'h300) begin miscompares++; $display("FAIL pp_top3 got %h want 300", RAS_top); end
      vectors++; if (dut.count_q !== 4'd3) begin miscompares++; $display("FAIL pp_count3 got %0d want 3", dut.count_q); end
      do_pop();
      vectors++; if (RAS_top !== 32'h200) begin miscompares++; $display("FAIL pp_pop_top got %h want 200", RAS_top); end
      vectors++; if (RAS_empty !== 1'b0) begin miscompares++; $display("FAIL pp_pop_empty got %0b want 0", RAS_empty); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 1; i <= 9; i++) do_push(32'h10 * i);
      vectors++; if (dut.count_q !== 4'd8) begin miscompares++; $display("FAIL wrap_count got %0d want 8", dut.count_q); end
      vectors++; if (RAS_top !== 32'h90) begin miscompares++; $display("FAIL wrap_top got %h want 90", RAS_top); end
      for (int k = 1; k <= 7; k++) begin
         do_pop();
         vectors++;
         if (RAS_top !== 32'h90 - 32'h10 * k || RAS_empty !== 1'b0) begin
            miscompares++; $display("FAIL wrap_pop%0d got top %h empty %0b want top %h empty 0", k, RAS_top, RAS_empty, 32'h90 - 32'h10 * k);
         end
      end
      do_pop();
      vectors++; if (RAS_empty !== 1'b1) begin miscompares++; $display("FAIL wrap_last_empty got %0b want 1", RAS_empty); end
      do_pop();
      vectors++; if (RAS_empty !== 1'b1 || dut.count_q !== 4'd0) begin miscompares++; $display("FAIL pop_on_empty got empty %0b count %0d want 1 0", RAS_empty, dut.count_q); end
      vectors++; if (RAS_top !== 32'h80) begin miscompares++; $display("FAIL pop_on_empty_ptr got top %h want 80", RAS_top); end
   endtask

   task automatic test_rollback_push();
      do_reset();
      do_push(32'h100); do_push(32'h200);
      do_pop(); do_pop();
      vectors++; if (RAS_empty !== 1'b1) begin miscompares++; $display("FAIL rbpush_pre_empty got %0b want 1", RAS_empty); end
      cyc(0, 0, 0, 0, 1, 1, 0, 0, 1);
      vectors++; if (RAS_top !== 32'h200) begin miscompares++; $display("FAIL rbpush_top got %h want 200", RAS_top); end
      vectors++; if (dut.count_q !== 4'd2) begin miscompares++; $display("FAIL rbpush_count got %0d want 2", dut.count_q); end
   endtask

   task automatic test_rollback_pop();
      do_reset();
      do_push(32'h100); do_push(32'h400);
      vectors++; if (RAS_top !== 32'h400) begin miscompares++; $display("FAIL rbpop_pre_top got %h want 400", RAS_top); end
      cyc(0, 0, 0, 1, 0, 0, 0, 0, 1);
      vectors++; if (RAS_top !== 32'h100 || dut.count_q !== 4'd1) begin miscompares++; $display("FAIL rbpop got top %h count %0d want 100 1", RAS_top, dut.count_q); end
      cyc(1, 32'h999, 0, 0, 0, 1, 0, 0, 1);
      vectors++; if (RAS_top !== 32'h400 || dut.count_q !== 4'd2) begin miscompares++; $display("FAIL rb_push_ignored got top %h count %0d want 400 2", RAS_top, dut.count_q); end
   endtask

   task automatic test_rollback_clamp();
      do_reset();
      for (int i = 1; i <= 8; i++) do_push(32'hA0 + i);
      do_pop();
      cyc(0, 0, 0, 0, 1, 1, 0, 0, 1);
      vectors++; if (dut.count_q !== 4'd8 || RAS_top !== 32'hA1) begin miscompares++; $display("FAIL rb_clamp got count %0d top %h want 8 a1", dut.count_q, RAS_top); end
   endtask

   task automatic test_push_pop_same();
      do_reset();
      do_push(32'h100);
      cyc(1, 32'h500, 1, 0, 0, 0, 0, 0, 1);
      vectors++; if (RAS_top !== 32'h500 || dut.count_q !== 4'd1) begin miscompares++; $display("FAIL pushpop got top %h count %0d want 500 1", RAS_top, dut.count_q); end
      do_reset();
      cyc(1, 32'h600, 1, 0, 0, 0, 0, 0, 1);
      vectors++; if (RAS_top !== 32'h600 || RAS_empty !== 1'b0) begin miscompares++; $display("FAIL pushpop_empty got top %h empty %0b want 600 0", RAS_top, RAS_empty); end
   endtask

   task automatic test_ra_track();
      do_reset();
      cyc(0, 0, 0, 0, 0, 0, 1, 5'd8, 1);
      vectors++; if (RAS_ra_track !== 5'd8) begin miscompares++; $display("FAIL ra_load got %0d want 8", RAS_ra_track); end
      do_push(32'h44);
      vectors++; if (RAS_ra_track !== 5'd1) begin miscompares++; $display("FAIL ra_push got %0d want 1", RAS_ra_track); end
      cyc(1, 32'h48, 0, 0, 0, 0, 1, 5'd0, 1);
      vectors++; if (RAS_ra_track !== 5'd0) begin miscompares++; $display("FAIL ra_en_over_push got %0d want 0", RAS_ra_track); end
      cyc(0, 0, 0, 1, 1, 0, 0, 0, 1);
      vectors++; if (RAS_ra_track !== 5'd0) begin miscompares++; $display("FAIL ra_rollback_hold got %0d want 0", RAS_ra_track); end
      cyc(1, 32'h4C, 0, 1, 1, 1, 1, 5'd9, 0);
      vectors++; if (RAS_ra_track !== 5'd1 || RAS_empty !== 1'b1) begin miscompares++; $display("FAIL ra_reset got ra %0d empty %0b want 1 1", RAS_ra_track, RAS_empty); end
   endtask

   initial begin
      RAS_push = 0; RAS_pop = 0; RAS_push_data = 0; RAS_rollback_pop_id = 0;
      RAS_rollback_push_id = 0; RAS_rollback_push_ex = 0; WR_ra_track_en = 0;
      WR_ra_track_data = 0; rst_n = 0;
      test_reset();
      test_push_pop();
      test_wrap();
      test_rollback_push();
      test_rollback_pop();
      test_rollback_clamp();
      test_push_pop_same();
      test_ra_track();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
